// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus plus decode-stage handoff.
//   MemReq/MemAddr  fetch -> memory  read request and address
//   MemAck/MemData  memory -> fetch  acknowledge and read data
//   Instr/InstrAddr/InstrValid  fetch -> decode  registered instruction
//   Accept          decode -> fetch  decode consumes Instr this cycle
interface fetch_unit_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          MemReq;
    logic [AW-1:0] MemAddr;
    logic          MemAck;
    logic [DW-1:0] MemData;
    logic [DW-1:0] Instr;
    logic [AW-1:0] InstrAddr;
    logic          InstrValid;
    logic          Accept;

    modport master (
        output MemReq, MemAddr, Instr, InstrAddr, InstrValid,
        input  MemAck, MemData, Accept
    );

    modport slave (
        input  MemReq, MemAddr, Instr, InstrAddr, InstrValid,
        output MemAck, MemData, Accept
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the program counter and decode.
//   CLK       clock, rising edge
//   Init_n    asynchronous active-low reset
//   PC        current PC count
//   Halt      PC halt control, low only in the cycle decode accepts Instr
//   FetchErr  sticky watchdog error, cleared only by Init_n
//   bus       memory request/ack and decode handoff (master side)
module fetch_unit #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          Init_n,
    input  logic [AW-1:0] PC,
    output logic          Halt,
    output logic          FetchErr,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERROR} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic          mem_req;
    logic          instr_valid;

    always_ff @(posedge CLK or negedge Init_n)
        if (!Init_n) state <= IDLE;
        else         state <= nxt;

    // MemAck takes priority over the watchdog when both land in the same cycle
    always_comb begin
        nxt         = state;
        mem_req     = state == REQ;
        instr_valid = state == HOLD;
        FetchErr    = state == ERROR;
        Halt        = ~(state == HOLD && bus.Accept);
        case (state)
            IDLE:    nxt = REQ;
            REQ:     nxt = bus.MemAck ? HOLD : (cnt == CW'(TIMEOUT - 1)) ? ERROR : REQ;
            HOLD:    nxt = bus.Accept ? REQ : HOLD;
            default: nxt = ERROR;
        endcase
    end

    // cnt only runs while waiting in REQ, so it is already zero on every entry to REQ
    always_ff @(posedge CLK or negedge Init_n)
        if (!Init_n) begin
            cnt        <= '0;
            instr      <= '0;
            instr_addr <= '0;
        end else begin
            cnt <= (state == REQ && !bus.MemAck) ? cnt + 1'b1 : '0;
            if (state == REQ && bus.MemAck) begin
                instr      <= bus.MemData;
                instr_addr <= PC;
            end
        end

    assign bus.MemReq     = mem_req;
    assign bus.MemAddr    = mem_req ? PC : '0;
    assign bus.InstrValid = instr_valid;
    assign bus.Instr      = instr;
    assign bus.InstrAddr  = instr_addr;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a simple PC model.
module tb_fetch_unit;
    logic        CLK = 1'b0;
    logic        Init_n;
    logic [15:0] pc;
    logic [15:0] target;
    logic        Halt;
    logic        FetchErr;
    int          errors = 0;
    int          checks = 0;
    int          halt_lows = 0;

    fetch_unit_if #(.AW(16), .DW(16)) bus ();

    fetch_unit #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .CLK(CLK),
        .Init_n(Init_n),
        .PC(pc),
        .Halt(Halt),
        .FetchErr(FetchErr),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // counts PC load edges (Halt low at a rising edge)
    always @(posedge CLK)
        if (Init_n === 1'b1 && Halt === 1'b0) halt_lows++;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // reset, release mid-cycle, and return 1ns into the first REQ cycle
    task automatic do_reset(input logic [15:0] pc0);
        Init_n = 1'b0;
        bus.MemAck = 1'b0;
        bus.MemData = '0;
        bus.Accept = 1'b0;
        pc = pc0;
        target = pc0;
        tick();
        Init_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        Init_n = 1'b0;
        bus.MemAck = 1'b0;
        bus.MemData = '0;
        bus.Accept = 1'b0;
        pc = 16'h0000;
        target = 16'h0000;
        #3;
        checks++;
        if ({bus.MemReq, bus.InstrValid, FetchErr, Halt} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0001", {bus.MemReq, bus.InstrValid, FetchErr, Halt});
        end
        checks++;
        if ({bus.Instr, bus.InstrAddr, bus.MemAddr} !== 48'h0) begin
            errors++;
            $display("FAIL reset_regs got=%h exp=0", {bus.Instr, bus.InstrAddr, bus.MemAddr});
        end
    endtask

    task automatic test_fetch;
        tick();
        Init_n = 1'b1;
        #1;
        checks++;
        if (bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_settle MemReq got=%b exp=0", bus.MemReq);
        end
        tick();
        checks++;
        if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL req1 got=%b/%h exp=1/0000", bus.MemReq, bus.MemAddr);
        end
        tick();
        bus.MemAck = 1'b1;
        bus.MemData = 16'h1234;
        #1;
        checks++;
        if ({bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL req2 got=%b/%h/%b exp=1/0000/0", bus.MemReq, bus.MemAddr, bus.InstrValid);
        end
        tick();
        bus.MemAck = 1'b0;
        #1;
        checks++;
        if ({bus.InstrValid, bus.Instr, bus.InstrAddr, Halt, bus.MemReq} !== {1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold1 got=%b/%h/%h/%b/%b exp=1/1234/0000/1/0",
                     bus.InstrValid, bus.Instr, bus.InstrAddr, Halt, bus.MemReq);
        end
    endtask

    task automatic test_accept;
        tick();
        bus.Accept = 1'b1;
        target = 16'h0002;
        #1;
        checks++;
        if (Halt !== 1'b0) begin
            errors++;
            $display("FAIL accept_halt got=%b exp=0", Halt);
        end
        tick();
        pc = target;
        bus.Accept = 1'b0;
        #1;
        checks++;
        if ({Halt, bus.MemReq, bus.MemAddr, bus.InstrValid} !== {1'b1, 1'b1, 16'h0002, 1'b0}) begin
            errors++;
            $display("FAIL after_accept got=%b/%b/%h/%b exp=1/1/0002/0",
                     Halt, bus.MemReq, bus.MemAddr, bus.InstrValid);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        do_reset(16'h0010);
        base = halt_lows;
        for (int i = 0; i < 4; i++) begin
            bus.MemAck = 1'b1;
            bus.MemData = 16'hA000 + 16'(i);
            #1;
            checks++;
            if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'h0010 + 16'(2 * i)}) begin
                errors++;
                $display("FAIL b2b_req[%0d] got=%b/%h exp=1/%h", i, bus.MemReq, bus.MemAddr, 16'h0010 + 16'(2 * i));
            end
            tick();
            bus.MemAck = 1'b0;
            bus.Accept = 1'b1;
            target = pc + 16'h2;
            #1;
            checks++;
            if ({bus.InstrValid, bus.Instr, bus.InstrAddr, Halt} !== {1'b1, 16'hA000 + 16'(i), 16'h0010 + 16'(2 * i), 1'b0}) begin
                errors++;
                $display("FAIL b2b_hold[%0d] got=%b/%h/%h/%b exp=1/%h/%h/0", i,
                         bus.InstrValid, bus.Instr, bus.InstrAddr, Halt, 16'hA000 + 16'(i), 16'h0010 + 16'(2 * i));
            end
            tick();
            pc = target;
            bus.Accept = 1'b0;
        end
        checks++;
        if (halt_lows - base !== 4 || pc !== 16'h0018) begin
            errors++;
            $display("FAIL b2b_pc_loads got=%0d/%h exp=4/0018", halt_lows - base, pc);
        end
    endtask

    task automatic test_hold_stall;
        do_reset(16'h0040);
        bus.MemAck = 1'b1;
        bus.MemData = 16'hBEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MemAck = i[0];
            bus.MemData = 16'h1111 * 16'(i + 1);
            bus.Accept = 1'b0;
            #1;
            checks++;
            if ({bus.Instr, bus.InstrAddr, bus.MemReq, Halt, bus.InstrValid} !== {16'hBEEF, 16'h0040, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL stall[%0d] got=%h/%h/%b/%b/%b exp=beef/0040/0/1/1", i,
                         bus.Instr, bus.InstrAddr, bus.MemReq, Halt, bus.InstrValid);
            end
            tick();
        end
        bus.MemAck = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset(16'h0080);
        for (int k = 1; k <= 15; k++) begin
            #1;
            checks++;
            if ({bus.MemReq, FetchErr} !== 2'b10) begin
                errors++;
                $display("FAIL wd_req[%0d] got=%b/%b exp=1/0", k, bus.MemReq, FetchErr);
            end
            tick();
        end
        checks++;
        if ({bus.MemReq, FetchErr, Halt, bus.InstrValid} !== 4'b0110) begin
            errors++;
            $display("FAIL wd_error got=%b exp=0110", {bus.MemReq, FetchErr, Halt, bus.InstrValid});
        end
        bus.MemAck = 1'b1;
        bus.MemData = 16'hDEAD;
        tick();
        bus.MemAck = 1'b0;
        tick();
        checks++;
        if ({bus.MemReq, FetchErr, bus.InstrValid, bus.Instr} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wd_sticky got=%b/%b/%b/%h exp=0/1/0/0000", bus.MemReq, FetchErr, bus.InstrValid, bus.Instr);
        end
        do_reset(16'h0090);
        for (int k = 1; k <= 14; k++) tick();
        bus.MemAck = 1'b1;
        bus.MemData = 16'h5A5A;
        #1;
        checks++;
        if (bus.MemReq !== 1'b1) begin
            errors++;
            $display("FAIL wd_last_req got=%b exp=1", bus.MemReq);
        end
        tick();
        bus.MemAck = 1'b0;
        #1;
        checks++;
        if ({bus.InstrValid, FetchErr, bus.Instr, bus.InstrAddr} !== {1'b1, 1'b0, 16'h5A5A, 16'h0090}) begin
            errors++;
            $display("FAIL wd_ack15 got=%b/%b/%h/%h exp=1/0/5a5a/0090", bus.InstrValid, FetchErr, bus.Instr, bus.InstrAddr);
        end
    endtask

    task automatic test_async_reset;
        do_reset(16'h0020);
        #2;
        Init_n = 1'b0;
        #1;
        checks++;
        if (bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL areset_req got=%b exp=0", bus.MemReq);
        end
        #1;
        Init_n = 1'b1;
        #1;
        checks++;
        if (bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle got=%b exp=0", bus.MemReq);
        end
        tick();
        checks++;
        if ({bus.MemReq, bus.MemAddr} !== {1'b1, 16'h0020}) begin
            errors++;
            $display("FAIL areset_reenter got=%b/%h exp=1/0020", bus.MemReq, bus.MemAddr);
        end
        bus.MemAck = 1'b1;
        bus.MemData = 16'h7777;
        tick();
        bus.MemAck = 1'b0;
        #2;
        Init_n = 1'b0;
        #1;
        checks++;
        if ({bus.InstrValid, bus.Instr, bus.MemReq} !== {1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL areset_hold got=%b/%h/%b exp=0/0000/0", bus.InstrValid, bus.Instr, bus.MemReq);
        end
        tick();
        Init_n = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if (FetchErr !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_err got=%b exp=1", FetchErr);
        end
        #2;
        Init_n = 1'b0;
        #1;
        checks++;
        if ({FetchErr, Halt} !== 2'b01) begin
            errors++;
            $display("FAIL areset_err got=%b exp=01", {FetchErr, Halt});
        end
        Init_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_accept();
        test_back_to_back();
        test_hold_stall();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter. Consumes the 16-bit PC count and issues a request/acknowledge read to instruction memory.
- Holds the returned word in an instruction register until the decode stage accepts it.
- Drives the PC's Halt input so the PC advances exactly once per instruction accepted.
- A watchdog aborts fetches that memory never acknowledges.

Parameters:
AW, 16, address width (matches PC count width)
DW, 16, instruction word width
TIMEOUT, 15, max cycles in REQ without MemAck before error (>=2)

Ports:
CLK  input  1  clock, all state updates on rising edge
Init_n  input  1  asynchronous active-low reset
PC  input  AW  current PC count
Halt  output  1  to PC Halt input; 0 only in the retire cycle
MemReq  output  1  instruction-memory read request
MemAddr  output  AW  read address, equals PC while MemReq=1, else 0
MemAck  input  1  memory has data on MemData this cycle
MemData  input  DW  read data, valid when MemAck=1
Instr  output  DW  registered instruction
InstrAddr  output  AW  address Instr was fetched from
InstrValid  output  1  Instr valid, awaiting Accept
Accept  input  1  decode consumes Instr this cycle
FetchErr  output  1  sticky watchdog error flag

Behaviour:
Reset:
- Init_n low: state=IDLE, cnt=0, Instr=0, InstrAddr=0, InstrValid=0, MemReq=0, FetchErr=0, Halt=1, immediately.

States:
- IDLE:
  - Halt=1, MemReq=0.
  - Next cycle -> REQ unconditionally; this gives one settle cycle after reset.
- REQ:
  - MemReq=1, MemAddr=PC (combinational); PC is stable because Halt=1.
  - cnt increments each cycle.
  - MemAck=1 -> Instr<=MemData, InstrAddr<=PC, InstrValid<=1, cnt<=0, -> HOLD.
  - Else if cnt==TIMEOUT-1 -> ERROR, MemReq drops next cycle.
  - If MemAck=1 and the timeout coincide in the same cycle, MemAck wins.
- HOLD:
  - InstrValid=1, MemReq=0.
  - Accept=1 -> Halt=0 this cycle (combinational: Halt = ~(state==HOLD & Accept)), InstrValid<=0, -> REQ.
  - The PC loads Target on the same edge, so REQ sees the new PC.
  - Accept=0 -> stay; Instr and InstrAddr are held stable.
- ERROR:
  - MemReq=0, Halt=1, InstrValid=0, FetchErr=1.
  - Exits only via Init_n.

General rules:
- Latency: MemAck sampled at edge N -> InstrValid=1 in cycle N+1. Minimum 2 cycles per instruction (REQ with same-cycle Ack, then HOLD with same-cycle Accept).
- MemAck outside REQ is ignored; MemData is never captured outside REQ.
- Accept outside HOLD is ignored; Halt stays 1.
- Reset mid-REQ or mid-HOLD aborts immediately: MemReq=0 and InstrValid=0 asynchronously, and the held instruction is discarded.
- cnt is ceil(log2(TIMEOUT+1)) bits wide and never wraps; it is cleared on entering REQ.
- Outputs change only on CLK edges or Init_n, except Halt and MemAddr as stated above.

Test Plan:
1. Reset release, PC=0x0000, MemAck asserted on 2nd REQ cycle with MemData=0x1234 -> MemReq=1 and MemAddr=0x0000 for 2 cycles; next cycle InstrValid=1, Instr=0x1234, InstrAddr=0x0000, Halt=1.
2. In HOLD, Accept=1 for one cycle, PC model loads Target=0x0002 -> Halt=0 for exactly that cycle; next cycle MemReq=1, MemAddr=0x0002, InstrValid=0.
3. Back-to-back: Ack in the first REQ cycle and Accept in the first HOLD cycle for 4 instructions at 0x0010, 0x0012, 0x0014, 0x0016 -> one instruction per 2 cycles; PC advances exactly 4 times; each InstrAddr matches.
4. Accept held low 5 cycles while MemData toggles and MemAck pulses -> Instr unchanged, MemReq=0, Halt=1 throughout.
5. No Ack for TIMEOUT=15 cycles -> MemReq drops after the 15th REQ cycle; FetchErr=1 sticky; Ack afterwards is ignored. Repeat with Ack on exactly the 15th cycle -> HOLD entered, FetchErr=0.
6. Init_n pulsed low mid-REQ and mid-HOLD (asynchronous, between edges) -> MemReq, InstrValid and FetchErr go 0 immediately; after release: IDLE for 1 cycle, then REQ.
